// File: rtl/display_salida.sv
// display_salida
// Display stage of the control datapath. A signed N-bit value is captured on
// enable, its magnitude is clamped to 9999 and converted to four BCD digits by
// a sequential shift-add-3 engine (one bit per cycle). The digits drive a
// multiplexed 4-digit active-low 7-segment display, and a separate LED shows
// the sign.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-low reset
//   dato      signed two's-complement value to display (N bits)
//   enable    capture strobe, honoured only while idle
//   ocupado   high from capture until the conversion finishes
//   listo     one-cycle pulse while new digits are presented
//   saturado  last captured magnitude exceeded 9999
//   signo     last captured value was negative
//   an        digit anodes, active-low, an[0] = units
//   seg       segments {g,f,e,d,c,b,a}, active-low
//
// state | meaning
// IDLE  | waiting for enable, display shows last result
// LOAD  | magnitude, clamp and sign taken from captured value
// CONV  | 14 shift-add-3 iterations, bit counter 13..0
// DONE  | new digits latched, listo high for this cycle

module display_salida #(
  parameter int N     = 18,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [N-1:0] dato,
  input  logic                enable,
  output logic                ocupado,
  output logic                listo,
  output logic                saturado,
  output logic                signo,
  output logic [3:0]          an,
  output logic [6:0]          seg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [N-1:0]     dato_r;
  logic [13:0]      mag;
  logic [15:0]      bcd;
  logic [3:0]       bit_cnt;
  logic             sign_r;
  logic             sat_r;
  logic [15:0]      digits;
  logic [CNT_W-1:0] cnt;

  // magnitude in N+1 bits so that -2^(N-1) does not overflow
  logic [N:0]  dato_ext;
  logic [N:0]  mag_full;
  logic        sat_load;
  logic [13:0] mag_load;

  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;

  logic [1:0]  sel;
  logic [3:0]  digit;
  logic [3:0]  blank;
  logic [3:0]  an_c;
  logic [6:0]  seg_c;

  function automatic logic [3:0] adj_nibble(input logic [3:0] d);
    adj_nibble = (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // next state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = LOAD;
      LOAD:    next_state = CONV;
      CONV:    if (bit_cnt == 4'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // load-time magnitude and clamp
  always_comb begin
    dato_ext = {dato_r[N-1], dato_r};
    mag_full = dato_r[N-1] ? -dato_ext : dato_ext;
    sat_load = (mag_full > (N+1)'(9999));
    mag_load = sat_load ? 14'd9999 : mag_full[13:0];
  end

  // one shift-add-3 step: adjust each nibble, then shift in the next magnitude bit
  always_comb begin
    bcd_adj   = {adj_nibble(bcd[15:12]), adj_nibble(bcd[11:8]),
                 adj_nibble(bcd[7:4]),   adj_nibble(bcd[3:0])};
    bcd_shift = {bcd_adj[14:0], mag[13]};
  end

  // display scan: digit select, leading-zero blanking, segment decode
  always_comb begin
    sel   = cnt[CNT_W-1 -: 2];
    digit = digits[sel*4 +: 4];
    blank[3] = (digits[15:12] == 4'd0);
    blank[2] = blank[3] && (digits[11:8] == 4'd0);
    blank[1] = blank[2] && (digits[7:4] == 4'd0);
    blank[0] = 1'b0;
    an_c  = ~(4'b0001 << sel);
    seg_c = blank[sel] ? 7'b1111111 : decode(digit);
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      dato_r   <= '0;
      mag      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      sign_r   <= 1'b0;
      sat_r    <= 1'b0;
      digits   <= '0;
      cnt      <= '0;
      ocupado  <= 1'b0;
      listo    <= 1'b0;
      signo    <= 1'b0;
      saturado <= 1'b0;
      an       <= 4'b1110;
      seg      <= 7'b1000000;
    end else begin
      cnt <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (enable) dato_r <= dato;
        end
        LOAD: begin
          mag     <= mag_load;
          bcd     <= '0;
          bit_cnt <= 4'd13;
          sign_r  <= dato_r[N-1];
          sat_r   <= sat_load;
        end
        CONV: begin
          bcd     <= bcd_shift;
          mag     <= {mag[12:0], 1'b0};
          bit_cnt <= bit_cnt - 4'd1;
          // the last iteration's result goes straight to the display registers
          if (bit_cnt == 4'd0) begin
            digits   <= bcd_shift;
            signo    <= sign_r;
            saturado <= sat_r;
          end
        end
        default: ;
      endcase
      ocupado <= (next_state != IDLE);
      listo   <= (next_state == DONE);
      an      <= an_c;
      seg     <= seg_c;
    end
  end

endmodule

// File: tb/tb_display_salida.sv
module tb_display_salida;

  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [17:0] dato;
  logic               enable;
  logic               ocupado, listo, saturado, signo;
  logic [3:0]         an;
  logic [6:0]         seg;
  logic               ocupado2, listo2, saturado2, signo2;
  logic [3:0]         an2;
  logic [6:0]         seg2;

  int errors = 0;
  int checks = 0;
  int cnt_e  = 0;

  typedef struct {
    int    at;
    bit    sg;
    bit    st;
    string nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cnt_e <= cnt_e + 1;

  display_salida #(.N(18), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .dato(dato), .enable(enable),
    .ocupado(ocupado), .listo(listo), .saturado(saturado), .signo(signo),
    .an(an), .seg(seg)
  );

  // short refresh counter so the scan is observable in a few cycles
  display_salida #(.N(18), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .dato(dato), .enable(enable),
    .ocupado(ocupado2), .listo(listo2), .saturado(saturado2), .signo(signo2),
    .an(an2), .seg(seg2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every listo pulse must match the oldest expected result
  always @(negedge clk) begin
    if (listo) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_listo: listo at cycle %0d with nothing pending", cnt_e);
      end else begin
        mon_e = sb.pop_front();
        if (cnt_e != mon_e.at || signo !== mon_e.sg || saturado !== mon_e.st) begin
          errors++;
          $display("FAIL %s: got cycle=%0d signo=%b saturado=%b expected cycle=%0d signo=%b saturado=%b",
                   mon_e.nm, cnt_e, signo, saturado, mon_e.at, mon_e.sg, mon_e.st);
        end
      end
    end
  end

  // called at a negedge; skip=1 means the first edge lands in DONE and must be ignored
  task automatic issue(input logic signed [17:0] v, input int skip,
                       input bit sg, input bit st, input string nm);
    exp_t e;
    e.at = cnt_e + 16 + skip;
    e.sg = sg;
    e.st = st;
    e.nm = nm;
    sb.push_back(e);
    dato   = v;
    enable = 1'b1;
    repeat (skip + 1) @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_listo(input string nm);
    for (int i = 0; i < 40 && !listo; i++) @(negedge clk);
    if (!listo) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: listo=0 after 40 cycles, expected 1", nm);
    end
  endtask

  task automatic check_disp(input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0,
                            input string nm);
    logic [6:0] got [4];
    int bad;
    for (int i = 0; i < 4; i++) got[i] = 7'h55;
    bad = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      case (an2)
        4'b1110: got[0] = seg2;
        4'b1101: got[1] = seg2;
        4'b1011: got[2] = seg2;
        4'b0111: got[3] = seg2;
        default: bad++;
      endcase
      @(negedge clk);
    end
    chk({nm, "_an_onehot"}, bad, 0);
    chk({nm, "_dig3"}, got[3], e3);
    chk({nm, "_dig2"}, got[2], e2);
    chk({nm, "_dig1"}, got[1], e1);
    chk({nm, "_dig0"}, got[0], e0);
  endtask

  initial begin
    logic [3:0] prev;
    int run;
    bit first;

    reset  = 1'b0;
    dato   = '0;
    enable = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_status", {ocupado, listo, signo, saturado}, 4'b0000);
    chk("reset_an", an, 4'b1110);
    chk("reset_seg", seg, S0);
    chk("reset_status_small", {ocupado2, listo2, signo2, saturado2, an2}, {4'b0000, 4'b1110});
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1234: ocupado window and listo timing
    chk("idle_ocupado", ocupado, 1'b0);
    issue(18'sd1234, 0, 1'b0, 1'b0, "conv_1234");
    for (int i = 0; i <= 16; i++) begin
      chk($sformatf("ocupado_1234_c%0d", i), ocupado, (i < 16) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    check_disp(S1, S2, S3, S4, "disp_1234");

    // 42 with an ignored enable mid-conversion
    issue(18'sd42, 0, 1'b0, 1'b0, "conv_42");
    repeat (4) @(negedge clk);
    dato   = 18'sd777;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_listo("conv_42");
    check_disp(S_BL, S_BL, S4, S2, "disp_42");
    repeat (20) @(negedge clk);
    chk("no_second_conv", ocupado, 1'b0);

    // saturation, most negative value, back-to-back start from DONE, zero
    issue(18'sd20000, 0, 1'b0, 1'b1, "conv_20000");
    wait_listo("conv_20000");
    check_disp(S9, S9, S9, S9, "disp_20000");
    issue(18'sh20000, 0, 1'b1, 1'b1, "conv_min");
    wait_listo("conv_min");
    issue(18'sd0, 1, 1'b0, 1'b0, "conv_0_b2b");
    wait_listo("conv_0");
    check_disp(S_BL, S_BL, S_BL, S0, "disp_0");

    // -57, display and sign hold old values mid-conversion
    issue(-18'sd57, 0, 1'b1, 1'b0, "conv_m57");
    repeat (5) @(negedge clk);
    chk("hold_signo", signo, 1'b0);
    wait_listo("conv_m57");
    check_disp(S_BL, S_BL, S5, S7, "disp_m57");

    // reset at k+8 aborts a conversion
    issue(18'sd1234, 0, 1'b0, 1'b0, "conv_abort");
    repeat (7) @(negedge clk);
    chk("hold_signo_neg", signo, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    sb.delete();
    chk("abort_status", {ocupado, listo, signo, saturado}, 4'b0000);
    chk("abort_an_seg", {an, seg}, {4'b1110, S0});
    @(negedge clk);
    reset = 1'b1;

    // scan order and 4-clock dwell on the CNT_W=4 instance
    prev  = an2;
    run   = 0;
    first = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an2 != prev) begin
        chk($sformatf("scan_seq_%0d", i), an2, {prev[2:0], prev[3]});
        if (!first) chk($sformatf("scan_dwell_%0d", i), run, 4);
        first = 1'b0;
        prev  = an2;
        run   = 1;
      end else begin
        run++;
      end
    end
    chk("abort_no_listo_pending", sb.size(), 0);
    chk("abort_ocupado", ocupado, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
